// File: rtl/pcs_tx_sequencer.sv
// 100BASE-T1 transmit PCS frame sequencer: paces 3B groups, inserts SSD/ESD delimiters, enforces IPG.
// Define PCS_TX_STATS_EN to add the frame/error statistics counters.
module pcs_tx_sequencer #(
   parameter int MIN_IPG = 8,
   parameter int IPG_W   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  tx_mode,
   input  logic        dat_valid,
   input  logic [2:0]  dat_3b,
   input  logic        dat_last,
   input  logic        dat_err,
   input  logic        scr_sx,
   output logic        dat_ready,
   output logic [1:0]  map_tx_mode,
   output logic        map_tx_enable,
   output logic [2:0]  map_sdn,
   output logic        map_sxn,
   output logic        ovr_valid,
   output logic [1:0]  ovr_ta,
   output logic [1:0]  ovr_tb,
   output logic        abort
`ifdef PCS_TX_STATS_EN
   ,
   input  logic        stats_clr,
   output logic [15:0] frame_cnt,
   output logic [7:0]  err_cnt
`endif
);

   localparam logic [1:0] MODE_SEND_Z = 2'd0;
   localparam logic [1:0] MODE_SEND_N = 2'd2;
   localparam logic [1:0] MODE_RSVD   = 2'd3;

   // Ternary pair encodings for the delimiter override
   localparam logic [1:0] TERN_P = 2'b11;
   localparam logic [1:0] TERN_Z = 2'b00;
   localparam logic [1:0] TERN_M = 2'b01;

   localparam logic [IPG_W-1:0] IPG_MAX = IPG_W'(MIN_IPG);

   typedef enum logic [3:0] {
      ST_DISABLE,
      ST_IDLE,
      ST_SSD1,
      ST_SSD2,
      ST_SSD3,
      ST_DATA,
      ST_ESD1,
      ST_ESD2,
      ST_ESD3
   } state_e;

   state_e           state_q;
   state_e           delim_next;
   logic [IPG_W-1:0] ipg_cnt_q;
   logic [IPG_W-1:0] ipg_cnt_inc;
   logic             err_q;
   logic             in_frame;
   logic             abort_evt;

   logic             dat_ready_q;
   logic [1:0]       map_tx_mode_q;
   logic             map_tx_enable_q;
   logic [2:0]       map_sdn_q;
   logic             map_sxn_q;
   logic             ovr_valid_q;
   logic [1:0]       ovr_ta_q;
   logic [1:0]       ovr_tb_q;
   logic             abort_q;

   assign in_frame = state_q inside {ST_SSD1, ST_SSD2, ST_SSD3, ST_DATA, ST_ESD1, ST_ESD2, ST_ESD3};

   // A frame is aborted either by leaving SEND_N mid-frame or by an empty upstream during DATA
   assign abort_evt = ((tx_mode != MODE_SEND_N) && in_frame) ||
                      ((tx_mode == MODE_SEND_N) && (state_q == ST_DATA) && !dat_valid);

   // Counter is advanced before the compare so the idle symbol leaving this cycle counts toward the gap
   assign ipg_cnt_inc = (ipg_cnt_q == IPG_MAX) ? ipg_cnt_q : ipg_cnt_q + 1'b1;

   always_comb begin
      // NOTE: default assigned first so every path drives delim_next and no latch is inferred
      delim_next = ST_DISABLE;
      case (state_q)
         ST_SSD1: delim_next = ST_SSD2;
         ST_SSD2: delim_next = ST_SSD3;
         ST_SSD3: delim_next = ST_DATA;
         ST_ESD1: delim_next = ST_ESD2;
         ST_ESD2: delim_next = ST_ESD3;
         default: delim_next = ST_DISABLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_DISABLE;
         ipg_cnt_q       <= IPG_MAX;
         err_q           <= 1'b0;
         dat_ready_q     <= 1'b0;
         map_tx_mode_q   <= MODE_SEND_Z;
         map_tx_enable_q <= 1'b0;
         map_sdn_q       <= 3'd0;
         map_sxn_q       <= 1'b0;
         ovr_valid_q     <= 1'b0;
         ovr_ta_q        <= TERN_Z;
         ovr_tb_q        <= TERN_Z;
         abort_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking defaults make every output a one-cycle registered value unless overridden below
         dat_ready_q     <= 1'b0;
         map_tx_mode_q   <= MODE_SEND_N;
         map_tx_enable_q <= 1'b0;
         map_sdn_q       <= 3'd0;
         map_sxn_q       <= scr_sx;
         ovr_valid_q     <= 1'b0;
         ovr_ta_q        <= TERN_Z;
         ovr_tb_q        <= TERN_Z;
         abort_q         <= abort_evt;

         if (tx_mode != MODE_SEND_N) begin
            state_q       <= ST_DISABLE;
            ipg_cnt_q     <= '0;
            map_tx_mode_q <= (tx_mode == MODE_RSVD) ? MODE_SEND_Z : tx_mode;
            map_sxn_q     <= 1'b0;
         end else begin
            unique case (state_q)
               ST_DISABLE: begin
                  state_q   <= ST_IDLE;
                  ipg_cnt_q <= '0;
               end

               ST_IDLE: begin
                  ipg_cnt_q <= ipg_cnt_inc;
                  if (dat_valid && (ipg_cnt_inc == IPG_MAX)) begin
                     state_q <= ST_SSD1;
                     err_q   <= 1'b0;
                  end
               end

               ST_SSD1, ST_SSD2, ST_SSD3, ST_ESD1, ST_ESD2: begin
                  map_tx_enable_q <= 1'b1;
                  ovr_valid_q     <= 1'b1;
                  ovr_ta_q        <= TERN_P;
                  ovr_tb_q        <= TERN_P;
                  dat_ready_q     <= (state_q == ST_SSD3);
                  state_q         <= delim_next;
               end

               ST_DATA: begin
                  map_tx_enable_q <= 1'b1;
                  if (dat_valid) begin
                     map_sdn_q <= dat_3b;
                     err_q     <= err_q | dat_err;
                     if (dat_last) begin
                        state_q <= ST_ESD1;
                     end else begin
                        dat_ready_q <= 1'b1;
                     end
                  end else begin
                     // Underrun: ESD1 goes out on this edge so no empty symbol is sent
                     err_q       <= 1'b1;
                     ovr_valid_q <= 1'b1;
                     ovr_ta_q    <= TERN_P;
                     ovr_tb_q    <= TERN_P;
                     state_q     <= ST_ESD2;
                  end
               end

               ST_ESD3: begin
                  map_tx_enable_q <= 1'b1;
                  ovr_valid_q     <= 1'b1;
                  ovr_ta_q        <= err_q ? TERN_M : TERN_P;
                  ovr_tb_q        <= err_q ? TERN_P : TERN_M;
                  state_q         <= ST_IDLE;
                  ipg_cnt_q       <= '0;
               end

               default: begin
                  state_q <= ST_DISABLE;
               end
            endcase
         end
      end
   end

   assign dat_ready     = dat_ready_q;
   assign map_tx_mode   = map_tx_mode_q;
   assign map_tx_enable = map_tx_enable_q;
   assign map_sdn       = map_sdn_q;
   assign map_sxn       = map_sxn_q;
   assign ovr_valid     = ovr_valid_q;
   assign ovr_ta        = ovr_ta_q;
   assign ovr_tb        = ovr_tb_q;
   assign abort         = abort_q;

`ifdef PCS_TX_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [7:0]  err_cnt_q;
   logic        esd3_evt;
   logic        err_evt;

   assign esd3_evt = (tx_mode == MODE_SEND_N) && (state_q == ST_ESD3);
   assign err_evt  = (esd3_evt && err_q) || abort_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else if (stats_clr) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (esd3_evt && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 1'b1;
         if (err_evt && (err_cnt_q != '1))    err_cnt_q   <= err_cnt_q + 1'b1;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_pcs_tx_sequencer.sv
// Directed self-checking bench for pcs_tx_sequencer: frames, error/underrun ESD, IPG spacing, mode changes, reset.
module tb_pcs_tx_sequencer;

   localparam int MIN_IPG = 8;
   localparam int LOG_MAX = 256;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] tx_mode;
   logic       dat_valid;
   logic [2:0] dat_3b;
   logic       dat_last;
   logic       dat_err;
   logic       scr_sx;
   logic       dat_ready;
   logic [1:0] map_tx_mode;
   logic       map_tx_enable;
   logic [2:0] map_sdn;
   logic       map_sxn;
   logic       ovr_valid;
   logic [1:0] ovr_ta;
   logic [1:0] ovr_tb;
   logic       abort;

   typedef struct {
      logic [2:0] d;
      logic       last;
      logic       err;
   } grp_t;

   typedef struct {
      logic       en;
      logic       ovr;
      logic [1:0] ta;
      logic [1:0] tb;
      logic [2:0] sdn;
      logic       ab;
      logic [1:0] mode;
   } obs_t;

   grp_t up_q[$];
   obs_t log_a[LOG_MAX];
   int   log_n;
   int   checks   = 0;
   int   failures = 0;

   pcs_tx_sequencer #(.MIN_IPG(MIN_IPG), .IPG_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tx_mode       (tx_mode),
      .dat_valid     (dat_valid),
      .dat_3b        (dat_3b),
      .dat_last      (dat_last),
      .dat_err       (dat_err),
      .scr_sx        (scr_sx),
      .dat_ready     (dat_ready),
      .map_tx_mode   (map_tx_mode),
      .map_tx_enable (map_tx_enable),
      .map_sdn       (map_sdn),
      .map_sxn       (map_sxn),
      .ovr_valid     (ovr_valid),
      .ovr_ta        (ovr_ta),
      .ovr_tb        (ovr_tb),
      .abort         (abort)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Upstream model: presents the head of up_q, pops it on a handshake
   task automatic drive();
      if (up_q.size() > 0) begin
         dat_valid = 1'b1;
         dat_3b    = up_q[0].d;
         dat_last  = up_q[0].last;
         dat_err   = up_q[0].err;
      end else begin
         dat_valid = 1'b0;
         dat_3b    = 3'd0;
         dat_last  = 1'b0;
         dat_err   = 1'b0;
      end
   endtask

   task automatic tick();
      logic hs;
      hs = dat_valid && dat_ready;
      @(posedge clk);
      #1;
      if (hs && (up_q.size() > 0)) up_q.delete(0);
      drive();
      if (log_n < LOG_MAX) begin
         log_a[log_n] = '{map_tx_enable, ovr_valid, ovr_ta, ovr_tb, map_sdn, abort, map_tx_mode};
         log_n++;
      end
   endtask

   task automatic push_frame(input int n, input int err_idx, input bit with_last);
      for (int i = 0; i < n; i++) begin
         grp_t g;
         g.d    = 3'(i + 1);
         g.last = with_last && (i == n - 1);
         g.err  = (i == err_idx);
         up_q.push_back(g);
      end
   endtask

   task automatic find_start(input int from, output int s);
      s = -1;
      for (int i = from; i < log_n; i++) begin
         if (log_a[i].en && (i == 0 || !log_a[i-1].en)) begin
            s = i;
            break;
         end
      end
   endtask

   task automatic count_aborts(output int c);
      c = 0;
      for (int i = 0; i < log_n; i++) if (log_a[i].ab) c++;
   endtask

   // Expected line sequence: 3x SSD (11/11), groups 1..n, ESD 11/11, 11/11, then 11/01 or 01/11, then idle
   task automatic verify_frame(input string tag, input int s, input int n, input bit err);
      logic [1:0] ta3;
      logic [1:0] tb3;
      ta3 = err ? 2'b01 : 2'b11;
      tb3 = err ? 2'b11 : 2'b01;
      checks++;
      if (s < 0 || s + n + 7 > log_n) begin
         failures++;
         $display("FAIL %s_start: frame start index %0d, log length %0d", tag, s, log_n);
         return;
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (log_a[s+k].en !== 1'b1 || log_a[s+k].ovr !== 1'b1 ||
             log_a[s+k].ta !== 2'b11 || log_a[s+k].tb !== 2'b11) begin
            failures++;
            $display("FAIL %s_ssd%0d: got en=%b ovr=%b ta=%b tb=%b, want en=1 ovr=1 ta=11 tb=11",
                     tag, k + 1, log_a[s+k].en, log_a[s+k].ovr, log_a[s+k].ta, log_a[s+k].tb);
         end
      end
      for (int k = 0; k < n; k++) begin
         checks++;
         if (log_a[s+3+k].en !== 1'b1 || log_a[s+3+k].ovr !== 1'b0 || log_a[s+3+k].sdn !== 3'(k + 1)) begin
            failures++;
            $display("FAIL %s_data%0d: got en=%b ovr=%b sdn=%0d, want en=1 ovr=0 sdn=%0d",
                     tag, k + 1, log_a[s+3+k].en, log_a[s+3+k].ovr, log_a[s+3+k].sdn, k + 1);
         end
      end
      for (int k = 0; k < 3; k++) begin
         logic [1:0] wta;
         logic [1:0] wtb;
         wta = (k == 2) ? ta3 : 2'b11;
         wtb = (k == 2) ? tb3 : 2'b11;
         checks++;
         if (log_a[s+3+n+k].en !== 1'b1 || log_a[s+3+n+k].ovr !== 1'b1 ||
             log_a[s+3+n+k].ta !== wta || log_a[s+3+n+k].tb !== wtb) begin
            failures++;
            $display("FAIL %s_esd%0d: got en=%b ovr=%b ta=%b tb=%b, want en=1 ovr=1 ta=%b tb=%b",
                     tag, k + 1, log_a[s+3+n+k].en, log_a[s+3+n+k].ovr,
                     log_a[s+3+n+k].ta, log_a[s+3+n+k].tb, wta, wtb);
         end
      end
      checks++;
      if (log_a[s+6+n].en !== 1'b0 || log_a[s+6+n].ovr !== 1'b0) begin
         failures++;
         $display("FAIL %s_post_esd: got en=%b ovr=%b, want en=0 ovr=0",
                  tag, log_a[s+6+n].en, log_a[s+6+n].ovr);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      tx_mode   = 2'd2;
      scr_sx    = 1'b1;
      up_q.delete();
      drive();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({dat_ready, map_tx_mode, map_tx_enable, map_sdn, map_sxn, ovr_valid, ovr_ta, ovr_tb, abort} !== 15'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %b, want all zero",
                  {dat_ready, map_tx_mode, map_tx_enable, map_sdn, map_sxn, ovr_valid, ovr_ta, ovr_tb, abort});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      int en_seen;
      log_n  = 0;
      scr_sx = 1'b0;
      repeat (20) tick();
      en_seen = 0;
      for (int i = 0; i < log_n; i++) if (log_a[i].en || log_a[i].ovr) en_seen++;
      checks++;
      if (en_seen != 0) begin
         failures++;
         $display("FAIL idle_quiet: got %0d cycles with enable/override, want 0", en_seen);
      end
      checks++;
      if (map_tx_mode !== 2'd2) begin
         failures++;
         $display("FAIL idle_mode: got %0d, want 2", map_tx_mode);
      end
      checks++;
      if (map_tx_enable !== 1'b0 || ovr_valid !== 1'b0 || dat_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_flags: got en=%b ovr=%b ready=%b, want 0 0 0", map_tx_enable, ovr_valid, dat_ready);
      end
      scr_sx = 1'b1;
      tick();
      checks++;
      if (map_sxn !== 1'b1 || map_sdn !== 3'd0) begin
         failures++;
         $display("FAIL idle_sxn_hi: got sxn=%b sdn=%0d, want sxn=1 sdn=0", map_sxn, map_sdn);
      end
      scr_sx = 1'b0;
      tick();
      checks++;
      if (map_sxn !== 1'b0) begin
         failures++;
         $display("FAIL idle_sxn_lo: got sxn=%b, want 0", map_sxn);
      end
   endtask

   task automatic test_frame(input string tag, input int err_idx);
      int s;
      int run;
      int ab;
      log_n = 0;
      push_frame(5, err_idx, 1'b1);
      drive();
      repeat (40) tick();
      find_start(0, s);
      verify_frame(tag, s, 5, err_idx >= 0);
      run = 0;
      if (s >= 0) for (int i = s; i < log_n && log_a[i].en; i++) run++;
      checks++;
      if (run != 11) begin
         failures++;
         $display("FAIL %s_enable_len: got %0d cycles, want 11", tag, run);
      end
      count_aborts(ab);
      checks++;
      if (ab != 0) begin
         failures++;
         $display("FAIL %s_abort: got %0d pulses, want 0", tag, ab);
      end
   endtask

   task automatic test_underrun();
      int s;
      int ab;
      log_n = 0;
      push_frame(2, -1, 1'b0);
      drive();
      repeat (40) tick();
      find_start(0, s);
      verify_frame("underrun", s, 2, 1'b1);
      count_aborts(ab);
      checks++;
      if (ab != 1) begin
         failures++;
         $display("FAIL underrun_abort_count: got %0d, want 1", ab);
      end
      checks++;
      if (s < 0 || log_a[s+5].ab !== 1'b1) begin
         failures++;
         $display("FAIL underrun_abort_pos: no abort on the ESD1 cycle (start=%0d)", s);
      end
   endtask

   task automatic test_back_to_back();
      int s1;
      int s2;
      int gap;
      log_n = 0;
      push_frame(3, -1, 1'b1);
      push_frame(2, -1, 1'b1);
      drive();
      repeat (50) tick();
      find_start(0, s1);
      verify_frame("b2b_a", s1, 3, 1'b0);
      find_start((s1 < 0) ? log_n : s1 + 1, s2);
      verify_frame("b2b_b", s2, 2, 1'b0);
      gap = s2 - (s1 + 3 + 3 + 2) - 1;
      checks++;
      if (s1 < 0 || s2 < 0 || gap != MIN_IPG) begin
         failures++;
         $display("FAIL b2b_gap: got %0d idle cycles (s1=%0d s2=%0d), want %0d", gap, s1, s2, MIN_IPG);
      end
   endtask

   task automatic test_mode_change();
      int  budget;
      int  busy;
      int  s;
      bit  found;
      log_n = 0;
      push_frame(6, -1, 1'b1);
      drive();
      found = 1'b0;
      for (budget = 0; budget < 40 && !found; budget++) begin
         tick();
         if (map_tx_enable && !ovr_valid && map_sdn == 3'd2) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL mode_reach_data: data group 2 not seen within 40 cycles");
      end
      tx_mode = 2'd1;
      tick();
      up_q.delete();
      drive();
      checks++;
      if (map_tx_mode !== 2'd1 || map_tx_enable !== 1'b0 || abort !== 1'b1 || ovr_valid !== 1'b0) begin
         failures++;
         $display("FAIL mode_switch: got mode=%0d en=%b abort=%b ovr=%b, want 1 0 1 0",
                  map_tx_mode, map_tx_enable, abort, ovr_valid);
      end
      tick();
      checks++;
      if (abort !== 1'b0) begin
         failures++;
         $display("FAIL mode_abort_pulse: abort still %b on second cycle, want 0", abort);
      end
      busy = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (map_tx_enable || ovr_valid) busy++;
      end
      checks++;
      if (busy != 0) begin
         failures++;
         $display("FAIL mode_no_esd: got %0d cycles with enable/override, want 0", busy);
      end
      tx_mode = 2'd2;
      log_n = 0;
      push_frame(2, -1, 1'b1);
      drive();
      repeat (40) tick();
      find_start(0, s);
      checks++;
      if (s < MIN_IPG) begin
         failures++;
         $display("FAIL mode_return_ipg: SSD after %0d idle cycles, want at least %0d", s, MIN_IPG);
      end
      checks++;
      if (log_a[0].mode !== 2'd2) begin
         failures++;
         $display("FAIL mode_return_mode: got %0d, want 2", log_a[0].mode);
      end
      verify_frame("mode_return", s, 2, 1'b0);
   endtask

   task automatic test_reserved_mode();
      tx_mode = 2'd3;
      tick();
      checks++;
      if (map_tx_mode !== 2'd0 || map_tx_enable !== 1'b0) begin
         failures++;
         $display("FAIL mode3_maps_z: got mode=%0d en=%b, want 0 0", map_tx_mode, map_tx_enable);
      end
      tx_mode = 2'd1;
      tick();
      checks++;
      if (map_tx_mode !== 2'd1 || dat_ready !== 1'b0) begin
         failures++;
         $display("FAIL mode1_follow: got mode=%0d ready=%b, want 1 0", map_tx_mode, dat_ready);
      end
      tx_mode = 2'd2;
      repeat (12) tick();
   endtask

   task automatic test_reset_mid_frame();
      bit found;
      int busy;
      log_n = 0;
      push_frame(5, -1, 1'b1);
      drive();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (map_tx_enable && !ovr_valid) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL rstmid_reach_data: data not seen within 40 cycles");
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if (map_tx_enable !== 1'b0 || ovr_valid !== 1'b0 || dat_ready !== 1'b0 || map_tx_mode !== 2'd0) begin
         failures++;
         $display("FAIL rstmid_async: got en=%b ovr=%b ready=%b mode=%0d, want 0 0 0 0",
                  map_tx_enable, ovr_valid, dat_ready, map_tx_mode);
      end
      up_q.delete();
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      busy = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (map_tx_enable || ovr_valid) busy++;
      end
      checks++;
      if (busy != 0) begin
         failures++;
         $display("FAIL rstmid_no_esd: got %0d cycles with enable/override, want 0", busy);
      end
   endtask

   initial begin
      log_n = 0;
      test_reset();
      test_idle();
      test_frame("frame_clean", -1);
      test_frame("frame_err", 2);
      test_underrun();
      test_back_to_back();
      test_mode_change();
      test_reserved_mode();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pcs_tx_sequencer.md
Name: pcs_tx_sequencer

Overview:
Transmit-side PCS frame sequencer for the 100BASE-T1 PHY. It sits between the 3B-group source (4B3B/scrambler path) and the ternary symbol mapper. It paces data groups with a valid/ready handshake, inserts SSD/ESD delimiters as forced ternary pairs, and enforces minimum inter-packet idle. It drives the mapper's tx_mode, tx_enable, sdn and sxn inputs from the PHY-control mode.

Parameters:
MIN_IPG, 8, minimum idle symbols (SEND_N, tx_enable low) between ESD3 and the next SSD1; legal range 1..(2^IPG_W)-1
IPG_W, 4, width of the IPG counter

Ports:
clk  in  1  symbol clock (66.67 MHz)
rst_n  in  1  asynchronous active-low reset
tx_mode  in  2  PHY-control mode: 0 SEND_Z, 1 SEND_I, 2 SEND_N, 3 reserved (treated as SEND_Z)
dat_valid  in  1  3B group available from upstream
dat_3b  in  3  scrambled data group
dat_last  in  1  qualifies dat_3b as last group of frame
dat_err  in  1  frame error flag (MII tx_er), sampled on any accepted group
scr_sx  in  1  scrambler Sx bit, passed through
dat_ready  out  1  group accepted this cycle when dat_valid&dat_ready
map_tx_mode  out  2  mode to mapper
map_tx_enable  out  1  high from SSD1 through ESD3 inclusive
map_sdn  out  3  data group to mapper
map_sxn  out  1  Sx bit to mapper
ovr_valid  out  1  delimiter override active; downstream mux selects ovr_ta/ovr_tb over mapper output
ovr_ta  out  2  forced TA pair (-1=01, 0=00, +1=11)
ovr_tb  out  2  forced TB pair
abort  out  1  one-cycle pulse: frame aborted by mode change or underrun

Behaviour:
- States: DISABLE, IDLE, SSD1, SSD2, SSD3, DATA, ESD1, ESD2, ESD3.
- Reset: state DISABLE, IPG counter = MIN_IPG (satisfied), error latch 0; all outputs 0.
- All outputs registered; one-cycle latency from state/input to output.
- DISABLE: entered whenever tx_mode != SEND_N (any state, any cycle), highest priority. map_tx_mode follows tx_mode, or 0 if tx_mode=3; map_tx_enable=0; dat_ready=0. When the mode change interrupts SSD1..ESD3, pulse abort for one cycle. Go to IDLE when tx_mode==SEND_N; IPG counter resets to 0.
- IDLE: map_tx_mode=2, map_tx_enable=0, map_sdn=0, map_sxn=scr_sx. IPG counter increments each cycle, saturating at MIN_IPG. Go to SSD1 when dat_valid=1 and counter==MIN_IPG; otherwise stay.
- SSD1..SSD3: one cycle each. ovr_valid=1 with ovr_ta=11, ovr_tb=11 (+1,+1). map_tx_enable=1; dat_ready=0. Error latch cleared in SSD1.
- DATA: dat_ready=1. When dat_valid=1, map_sdn=dat_3b and map_sxn=scr_sx on the next cycle, and the error latch ORs in dat_err. If dat_last=1 on the accepted group, go to ESD1. If dat_valid=0 in DATA (underrun), set the error latch, pulse abort, and go to ESD1.
- ESD1, ESD2: ovr (+1,+1). ESD3: ovr (+1,-1) = 11/01 when the error latch is 0, or ESD_ERR (-1,+1) = 01/11 when it is 1. dat_ready=0.
- After ESD3, go to IDLE with the IPG counter reset to 0. Back-to-back frames are therefore spaced by exactly MIN_IPG idle symbols.
- The upstream must hold dat_3b/dat_last/dat_err stable while dat_valid=1 and dat_ready=0.
- dat_last together with underrun cannot occur (dat_last requires dat_valid).
- Asserting rst_n low mid-frame returns to the reset state immediately; no ESD is sent.

Optional Feature:
PCS_TX_STATS_EN:
- Defined: adds outputs frame_cnt[15:0], err_cnt[7:0], and input stats_clr (synchronous clear). frame_cnt increments on each ESD3. err_cnt increments on each ESD3 with ESD_ERR, or on each abort. Both counters saturate and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then tx_mode=2, hold dat_valid=0 for 20 cycles -> map_tx_mode=2, map_tx_enable=0, ovr_valid=0, dat_ready=0.
- Frame of 5 groups 3'b001..3'b101, last on the 5th, dat_err=0, after IPG met -> 3 cycles ovr 11/11, then map_sdn 1,2,3,4,5, then ESD 11/11, 11/11, 11/01. map_tx_enable is high for 11 consecutive cycles.
- Same frame with dat_err=1 on group 3 -> ESD3 is 01/11, no abort pulse.
- dat_valid dropped after 2 groups -> abort pulse once; ESD_ERR sequence follows immediately.
- Frames offered back to back with MIN_IPG=8 -> exactly 8 idle cycles between ESD3 and the next SSD1.
- tx_mode forced to 1 during DATA -> next cycle map_tx_mode=1, map_tx_enable=0, abort pulse, no ESD. Return to mode 2 -> a new SSD only after MIN_IPG idle cycles.
